sprite_pixel_engine: RTL and testbench
======================================

// Module: sprite_pixel_engine
// PURPOSE
//  Sits directly downstream of sprite_manager. Receives fully fetched sprites (conf + pattern) over a
//  valid/ack handshake and stores up to NUM_SPRITES per scanline. On draw_start it scans x=0..255 at one
//  pixel/cycle and emits the winning sprite pixel to the layer mixer. Lowest slot index (load order) wins.
// PARAMETERS
//  NUM_SPRITES  16  sprite slots per scanline; CNT_W = $clog2(NUM_SPRITES+1)
// PORTS
//  clock         in   1       system clock
//  reset_l       in   1       reset, asynchronous, active-low
//  clear         in   1       sync clear: empty slots, return to LOAD (per-scanline restart)
//  sprite        in   sprite_reg_t  {conf{palette[3:0],x[7:0],w[1:0],x_mirror,fg_prio,bg_prio}, pat pixel_t[3:0][7:0]}
//  sprite_valid  in   1       sprite holds a complete sprite
//  sprite_ack    out  1       slot free and accepting; transfer = sprite_valid & sprite_ack
//  draw_start    in   1       pulse: begin pixel scan of stored sprites
//  pix_valid     out  1       pix_* fields valid this cycle
//  pix_x         out  8       screen x of emitted pixel
//  pix_opaque    out  1       some sprite covers pix_x with a non-transparent pixel
//  pix_color     out  8       {palette, pixel index}; 0 when !pix_opaque
//  pix_fg_prio   out  1       fg_prio of winning sprite; 0 when !pix_opaque
//  pix_bg_prio   out  1       bg_prio of winning sprite; 0 when !pix_opaque
//  draw_done     out  1       one-cycle pulse with the x=255 pixel
//  sprite_count  out  CNT_W   number of slots loaded
// BEHAVIOUR
//  Reset (reset_l low): state=LOAD, count=0, x counter=0, all slots invalid, every output 0.
//  clear: priority over all other inputs in every state; same effect as reset on the next edge.
//  The transfer in a clear cycle is dropped and sprite_ack is forced low.
//  FSM:
//   LOAD  sprite_ack = (count < NUM_SPRITES) & ~clear. Each transfer writes slot[count] and does count++.
//         draw_start -> DRAW. A transfer in the same cycle as draw_start is stored and drawn.
//         draw_start with count=0 is legal; the scan emits all-transparent pixels.
//   DRAW  sprite_ack=0. Issues x=0..255, one per cycle. After issuing x=255 -> HOLD.
//         draw_start is ignored here.
//   HOLD  sprite_ack=0, no output. Slots retained until clear -> LOAD.
//         draw_start is ignored here.
//  Full: when count==NUM_SPRITES, sprite_ack=0; the sprite stays pending upstream (upstream stall).
//  Latency: x issued in cycle k produces a registered pix_* in cycle k+1.
//   256 consecutive pix_valid cycles, no gaps. draw_done=1 in the same cycle as pix_x=255.
//  Per-slot hit test, for a valid slot:
//   c = {1'b0,x} - {1'b0,conf.x}, 9 bits. W = (w+1)*8.
//   Hit if c[8]==0 (no borrow) and c[7:0] < W. Pixels past x=255 are clipped; no wraparound.
//   Column: col = x_mirror ? (W-1-c) : c. Pixel = pat[col[4:3]][col[2:0]].
//   A pixel value of 0 is transparent and does not hit.
//  Winner: lowest slot index with an opaque hit. No winner -> pix_opaque=0 and color/prio=0.
//  clear during DRAW: the next cycle pix_valid=0 and draw_done is never pulsed.
//   Any in-flight pixel is discarded.
// STRUCTURE
//  Shared package sprite_defines already provides sprite_conf_t, sprite_reg_t and pixel_t (4 bits).
//  Add to it: SCREEN_W=256 and PIX_TRANSPARENT=4'd0.
//  Sub-module sprite_slot_pixel (combinational): (x, sprite_reg_t, slot_valid) -> (hit, pixel_t).
//   Instantiated NUM_SPRITES times.
//  Top level holds: FSM, slot regs + valid bits, x counter, fixed-priority select, output register.
// TESTING
//  1 Reset, then load 1 sprite {x=10,w=0,pal=3,pat[0]=1..8}, then draw_start.
//    -> pix_x=10..17 has color {3,1..8} and opaque=1; all other x opaque=0.
//    -> 256 valid cycles; draw_done coincides with x=255.
//  2 Same sprite with x_mirror=1 -> x=10 shows index 8, x=17 shows index 1.
//    w=3, x=250 -> x=250..255 drawn, nothing after; draw_done still at 255.
//  3 Slot0 {x=20,pat all 0 except col 2=5} and slot1 {x=20,pat all 7}.
//    -> x=22 index 5 from slot0; x=20,21,23..27 index 7 from slot1.
//    -> prio bits come from the winner.
//  4 Offer NUM_SPRITES+1 sprites back-to-back.
//    -> sprite_ack drops after the 16th; sprite_count=16; 17th held pending.
//    -> draw ignores the 17th.
//  5 Transfer and draw_start in the same cycle -> that sprite is drawn.
//    draw_start during DRAW/HOLD -> no effect.
//  6 clear at x=100 of DRAW -> pix_valid=0 the next cycle, no draw_done, count=0, state LOAD.
//    Mid-scan async reset -> all outputs 0 immediately.

Source files
------------

// File: rtl/sprite_defines_pkg.sv
// Shared sprite types for the sprite fetch/draw pipeline.
// Pixel scan constants and the draw-engine state encoding.
package sprite_defines;

    typedef logic [3:0] pixel_t;

    typedef struct packed {
        logic [3:0] palette;
        logic [7:0] x;
        logic [1:0] w;
        logic       x_mirror;
        logic       fg_prio;
        logic       bg_prio;
    } sprite_conf_t;

    typedef struct packed {
        sprite_conf_t          conf;
        pixel_t [3:0][7:0]     pat;
    } sprite_reg_t;

    localparam int     SCREEN_W        = 256;
    localparam pixel_t PIX_TRANSPARENT = 4'd0;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_DRAW,
        ST_HOLD
    } draw_state_t;

endpackage

// File: rtl/sprite_pixel_engine_slot.sv
// Per-slot hit test: does this stored sprite cover screen x with an
// opaque pixel, and which pattern pixel lands there.
module sprite_slot_pixel
    import sprite_defines::*;
(
    input  logic [7:0]  x,
    input  sprite_reg_t spr,
    input  logic        slot_valid,
    output logic        hit,
    output pixel_t      pixel
);

    logic [8:0] c;
    logic [5:0] width;
    logic [4:0] col;
    logic       in_range;

    always_comb begin
        // 9-bit difference: bit 8 set means x is left of the sprite
        c        = {1'b0, x} - {1'b0, spr.conf.x};
        width    = {1'b0, spr.conf.w, 3'b000} + 6'd8;
        in_range = ~c[8] & (c[7:0] < {2'b00, width});
        col      = spr.conf.x_mirror ? 5'(width - 6'd1 - {1'b0, c[4:0]})
                                     : c[4:0];
        pixel    = spr.pat[col[4:3]][col[2:0]];
        hit      = slot_valid & in_range & (pixel != PIX_TRANSPARENT);
    end

endmodule

// File: rtl/sprite_pixel_engine.sv
// Per-scanline sprite store and pixel scanner: loads fetched sprites,
// then walks x=0..255 emitting the lowest-slot opaque sprite pixel.
module sprite_pixel_engine
    import sprite_defines::*;
#(
    parameter  int NUM_SPRITES = 16,
    localparam int CNT_W       = $clog2(NUM_SPRITES + 1),
    localparam int IDX_W       = $clog2(NUM_SPRITES)
) (
    input  logic             clock,
    input  logic             reset_l,
    input  logic             clear,
    input  sprite_reg_t      sprite,
    input  logic             sprite_valid,
    output logic             sprite_ack,
    input  logic             draw_start,
    output logic             pix_valid,
    output logic [7:0]       pix_x,
    output logic             pix_opaque,
    output logic [7:0]       pix_color,
    output logic             pix_fg_prio,
    output logic             pix_bg_prio,
    output logic             draw_done,
    output logic [CNT_W-1:0] sprite_count
);

    draw_state_t             state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [7:0]              x_q, x_d;
    sprite_reg_t             slot_q [NUM_SPRITES];
    sprite_reg_t             slot_d [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]  valid_q, valid_d;

    logic                    pix_valid_q, pix_valid_d;
    logic [7:0]              pix_x_q, pix_x_d;
    logic                    pix_opaque_q, pix_opaque_d;
    logic [7:0]              pix_color_q, pix_color_d;
    logic                    pix_fg_q, pix_fg_d;
    logic                    pix_bg_q, pix_bg_d;
    logic                    draw_done_q, draw_done_d;

    logic [NUM_SPRITES-1:0]  hit;
    pixel_t                  hit_pix [NUM_SPRITES];
    logic                    take;
    logic                    drawing;
    logic                    win_hit;
    pixel_t                  win_pix;
    logic [3:0]              win_pal;
    logic                    win_fg;
    logic                    win_bg;

    assign sprite_ack = reset_l & (state_q == ST_LOAD) &
                        (count_q < CNT_W'(NUM_SPRITES)) & ~clear;
    assign take       = sprite_valid & sprite_ack;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
        sprite_slot_pixel u_slot (
            .x          (x_q),
            .spr        (slot_q[g]),
            .slot_valid (valid_q[g]),
            .hit        (hit[g]),
            .pixel      (hit_pix[g])
        );
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        x_d     = x_q;
        slot_d  = slot_q;
        valid_d = valid_q;
        if (clear) begin
            state_d = ST_LOAD;
            count_d = '0;
            x_d     = '0;
            valid_d = '0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (take) begin
                        slot_d[count_q[IDX_W-1:0]]  = sprite;
                        valid_d[count_q[IDX_W-1:0]] = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                    if (draw_start) begin
                        state_d = ST_DRAW;
                        x_d     = '0;
                    end
                end
                ST_DRAW: begin
                    // x wraps back to 0 as the scan finishes
                    x_d = x_q + 8'd1;
                    if (x_q == 8'hFF) state_d = ST_HOLD;
                end
                ST_HOLD: ;
                default: state_d = ST_LOAD;
            endcase
        end
    end

    always_comb begin
        win_hit = 1'b0;
        win_pix = PIX_TRANSPARENT;
        win_pal = '0;
        win_fg  = 1'b0;
        win_bg  = 1'b0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_hit = 1'b1;
                win_pix = hit_pix[i];
                win_pal = slot_q[i].conf.palette;
                win_fg  = slot_q[i].conf.fg_prio;
                win_bg  = slot_q[i].conf.bg_prio;
            end
        end
    end

    always_comb begin
        drawing      = (state_q == ST_DRAW) & ~clear;
        pix_valid_d  = drawing;
        pix_x_d      = drawing ? x_q : 8'd0;
        pix_opaque_d = drawing & win_hit;
        pix_color_d  = pix_opaque_d ? {win_pal, win_pix} : 8'd0;
        pix_fg_d     = pix_opaque_d & win_fg;
        pix_bg_d     = pix_opaque_d & win_bg;
        draw_done_d  = drawing & (x_q == 8'hFF);
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q      <= ST_LOAD;
            count_q      <= '0;
            x_q          <= '0;
            slot_q       <= '{default: '0};
            valid_q      <= '0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_opaque_q <= 1'b0;
            pix_color_q  <= '0;
            pix_fg_q     <= 1'b0;
            pix_bg_q     <= 1'b0;
            draw_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            x_q          <= x_d;
            slot_q       <= slot_d;
            valid_q      <= valid_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_opaque_q <= pix_opaque_d;
            pix_color_q  <= pix_color_d;
            pix_fg_q     <= pix_fg_d;
            pix_bg_q     <= pix_bg_d;
            draw_done_q  <= draw_done_d;
        end
    end

    assign pix_valid    = pix_valid_q;
    assign pix_x        = pix_x_q;
    assign pix_opaque   = pix_opaque_q;
    assign pix_color    = pix_color_q;
    assign pix_fg_prio  = pix_fg_q;
    assign pix_bg_prio  = pix_bg_q;
    assign draw_done    = draw_done_q;
    assign sprite_count = count_q;

endmodule

// File: tb/tb_sprite_pixel_engine.sv
// Bench for sprite_pixel_engine: directed scanline scenarios plus
// random sprite sets, checked every cycle against a scanline model.
module tb_sprite_pixel_engine;
    import sprite_defines::*;

    localparam int NS = 16;
    localparam int CW = $clog2(NS + 1);

    logic          clock = 1'b0;
    logic          reset_l = 1'b0;
    logic          clear = 1'b0;
    logic          sprite_valid = 1'b0;
    logic          draw_start = 1'b0;
    sprite_reg_t   sprite = '0;
    logic          sprite_ack;
    logic          pix_valid;
    logic [7:0]    pix_x;
    logic          pix_opaque;
    logic [7:0]    pix_color;
    logic          pix_fg_prio;
    logic          pix_bg_prio;
    logic          draw_done;
    logic [CW-1:0] sprite_count;

    always #5 clock = ~clock;

    sprite_pixel_engine #(.NUM_SPRITES(NS)) dut (
        .clock        (clock),
        .reset_l      (reset_l),
        .clear        (clear),
        .sprite       (sprite),
        .sprite_valid (sprite_valid),
        .sprite_ack   (sprite_ack),
        .draw_start   (draw_start),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_opaque   (pix_opaque),
        .pix_color    (pix_color),
        .pix_fg_prio  (pix_fg_prio),
        .pix_bg_prio  (pix_bg_prio),
        .draw_done    (draw_done),
        .sprite_count (sprite_count)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // ---------------- scanline model ----------------
    typedef enum {M_LOAD, M_DRAW, M_HOLD} mmode_t;
    sprite_reg_t m_q[$];
    mmode_t      mode = M_LOAD;
    int          m_x = 0;
    logic        e_valid = 1'b0;
    logic [7:0]  e_x = '0;
    logic [10:0] e_px = '0;
    logic        e_done = 1'b0;

    // {opaque, palette, index, fg, bg} of the first stored sprite that
    // paints screen column x
    function automatic logic [10:0] m_pixel(int x);
        for (int i = 0; i < m_q.size(); i++) begin
            sprite_reg_t s = m_q[i];
            int wd = (int'(s.conf.w) + 1) * 8;
            int sx = int'(s.conf.x);
            if (x >= sx && x < sx + wd) begin
                int c = x - sx;
                int col = s.conf.x_mirror ? wd - 1 - c : c;
                pixel_t p = s.pat[col / 8][col % 8];
                if (p != 4'd0)
                    return {1'b1, s.conf.palette, p,
                            s.conf.fg_prio, s.conf.bg_prio};
            end
        end
        return '0;
    endfunction

    initial forever begin
        @(posedge clock or negedge reset_l);
        e_valid = 1'b0; e_x = '0; e_px = '0; e_done = 1'b0;
        if (!reset_l || clear) begin
            m_q.delete();
            mode = M_LOAD;
            m_x = 0;
        end else begin
            case (mode)
                M_LOAD: begin
                    if (sprite_valid && m_q.size() < NS) m_q.push_back(sprite);
                    if (draw_start) begin
                        mode = M_DRAW;
                        m_x = 0;
                    end
                end
                M_DRAW: begin
                    e_valid = 1'b1;
                    e_x = 8'(m_x);
                    e_px = m_pixel(m_x);
                    e_done = (m_x == SCREEN_W - 1);
                    m_x++;
                    if (m_x == SCREEN_W) mode = M_HOLD;
                end
                default: ;
            endcase
        end
    end

    // ---------------- compare + capture ----------------
    logic [10:0] cap [256];
    int vcnt = 0;
    int ndone = 0;
    int done_x = -1;

    initial forever begin
        logic m_ack;
        @(negedge clock);
        m_ack = reset_l && mode == M_LOAD && m_q.size() < NS && !clear;
        chk("ack", 64'(sprite_ack), 64'(m_ack));
        chk("pix", {pix_valid, pix_x, pix_opaque, pix_color,
                    pix_fg_prio, pix_bg_prio, draw_done},
                   {e_valid, e_x, e_px, e_done});
        chk("count", 64'(sprite_count), 64'(m_q.size()));
        if (pix_valid) begin
            cap[pix_x] = {pix_opaque, pix_color, pix_fg_prio, pix_bg_prio};
            vcnt++;
        end
        if (draw_done) begin
            done_x = pix_x;
            ndone++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic send(sprite_reg_t s);
        bit got = 0;
        sprite = s;
        sprite_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            if (sprite_ack) got = 1;
        end
        if (!got) chk("send_timeout", 0, 1);
        cyc(1);
    endtask

    task automatic reset_cap();
        for (int i = 0; i < 256; i++) cap[i] = '0;
        vcnt = 0;
        ndone = 0;
        done_x = -1;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            if (draw_done) seen = 1;
        end
        if (!seen) chk("draw_done_timeout", 0, 1);
        cyc(2);
    endtask

    task automatic run_draw();
        reset_cap();
        draw_start = 1'b1;
        cyc(1);
        draw_start = 1'b0;
        wait_done();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    task automatic wait_x(int x);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            if (pix_valid && pix_x == 8'(x)) seen = 1;
        end
        if (!seen) chk("wait_x_timeout", 0, 1);
    endtask

    function automatic sprite_reg_t mk(logic [3:0] pal, logic [7:0] x,
                                       logic [1:0] w, logic mir,
                                       logic fg, logic bg);
        sprite_reg_t s = '0;
        s.conf.palette = pal;
        s.conf.x = x;
        s.conf.w = w;
        s.conf.x_mirror = mir;
        s.conf.fg_prio = fg;
        s.conf.bg_prio = bg;
        return s;
    endfunction

    // ---------------- scenarios ----------------
    initial begin
        sprite_reg_t s, a, b;

        cyc(3);
        chk("reset_ack", 64'(sprite_ack), 0);
        chk("reset_out", {pix_valid, pix_x, pix_opaque, pix_color,
                          pix_fg_prio, pix_bg_prio, draw_done,
                          sprite_count}, 0);
        reset_l = 1'b1;
        cyc(1);

        // single sprite, pattern 1..8
        s = mk(4'd3, 8'd10, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) s.pat[0][i] = 4'(i + 1);
        send(s);
        sprite_valid = 1'b0;
        cyc(1);
        chk("model_x10", m_pixel(10), {1'b1, 8'h31, 2'b00});
        chk("model_x17", m_pixel(17), {1'b1, 8'h38, 2'b00});
        chk("model_x18", m_pixel(18), 0);
        run_draw();
        chk("t1_x10", cap[10], {1'b1, 8'h31, 2'b00});
        chk("t1_x13", cap[13], {1'b1, 8'h34, 2'b00});
        chk("t1_x17", cap[17], {1'b1, 8'h38, 2'b00});
        chk("t1_x9", cap[9], 0);
        chk("t1_x18", cap[18], 0);
        chk("t1_vcnt", vcnt, 256);
        chk("t1_done_x", done_x, 255);
        chk("t1_ndone", ndone, 1);

        // mirrored
        do_clear();
        s.conf.x_mirror = 1'b1;
        send(s);
        sprite_valid = 1'b0;
        run_draw();
        chk("t2_mir_x10", cap[10], {1'b1, 8'h38, 2'b00});
        chk("t2_mir_x17", cap[17], {1'b1, 8'h31, 2'b00});

        // right-edge clipping
        do_clear();
        s = mk(4'd5, 8'd250, 2'd3, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) s.pat[r][c] = 4'd9;
        send(s);
        sprite_valid = 1'b0;
        run_draw();
        chk("t2_clip_x250", cap[250], {1'b1, 8'h59, 2'b10});
        chk("t2_clip_x255", cap[255], {1'b1, 8'h59, 2'b10});
        chk("t2_clip_x249", cap[249], 0);
        chk("t2_clip_nowrap", cap[0], 0);
        chk("t2_clip_done_x", done_x, 255);
        chk("t2_clip_vcnt", vcnt, 256);

        // overlap: slot0 wins only where opaque
        do_clear();
        a = mk(4'd1, 8'd20, 2'd0, 1'b0, 1'b1, 1'b0);
        a.pat[0][2] = 4'd5;
        b = mk(4'd2, 8'd20, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 8; c++) b.pat[0][c] = 4'd7;
        send(a);
        send(b);
        sprite_valid = 1'b0;
        run_draw();
        chk("t3_x22", cap[22], {1'b1, 8'h15, 2'b10});
        chk("t3_x20", cap[20], {1'b1, 8'h27, 2'b01});
        chk("t3_x27", cap[27], {1'b1, 8'h27, 2'b01});
        chk("t3_x28", cap[28], 0);

        // fill all slots, 17th stays pending
        do_clear();
        for (int i = 0; i < NS; i++) begin
            s = mk(4'(i), 8'(i * 15), 2'd0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 8; c++) s.pat[0][c] = 4'((i + c) % 15 + 1);
            send(s);
        end
        s = mk(4'd15, 8'd240, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) s.pat[0][c] = 4'd1;
        sprite = s;
        cyc(3);
        chk("t4_count", 64'(sprite_count), 16);
        chk("t4_ack", 64'(sprite_ack), 0);
        run_draw();
        chk("t4_x240", cap[240], 0);
        chk("t4_x0", cap[0], {1'b1, 8'h01, 2'b00});
        sprite_valid = 1'b0;

        // transfer coinciding with draw_start; restarts ignored
        do_clear();
        s = mk(4'd7, 8'd100, 2'd1, 1'b1, 1'b1, 1'b1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) s.pat[r][c] = 4'((r * 8 + c) % 15 + 1);
        reset_cap();
        sprite = s;
        sprite_valid = 1'b1;
        draw_start = 1'b1;
        cyc(1);
        sprite_valid = 1'b0;
        draw_start = 1'b0;
        cyc(50);
        draw_start = 1'b1;
        cyc(1);
        draw_start = 1'b0;
        wait_done();
        cyc(5);
        draw_start = 1'b1;
        cyc(1);
        draw_start = 1'b0;
        cyc(20);
        chk("t5_x100", cap[100], {1'b1, 8'h71, 2'b11});
        chk("t5_vcnt", vcnt, 256);
        chk("t5_ndone", ndone, 1);
        chk("t5_count", 64'(sprite_count), 1);

        // clear mid-scan
        do_clear();
        send(s);
        sprite_valid = 1'b0;
        reset_cap();
        draw_start = 1'b1;
        cyc(1);
        draw_start = 1'b0;
        wait_x(99);
        #1 clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(300);
        chk("t6_ndone", ndone, 0);
        chk("t6_vcnt", vcnt, 100);
        chk("t6_count", 64'(sprite_count), 0);
        chk("t6_ack_load", 64'(sprite_ack), 1);

        // async reset mid-scan
        send(s);
        sprite_valid = 1'b0;
        draw_start = 1'b1;
        cyc(1);
        draw_start = 1'b0;
        wait_x(50);
        #1 reset_l = 1'b0;
        #1;
        chk("async_rst_out", {pix_valid, pix_x, pix_opaque, pix_color,
                              pix_fg_prio, pix_bg_prio, draw_done,
                              sprite_count, sprite_ack}, 0);
        cyc(2);
        reset_l = 1'b1;
        cyc(1);

        // random sprite sets
        for (int r = 0; r < 8; r++) begin
            int n;
            do_clear();
            n = $urandom_range(0, 17);
            for (int k = 0; k < n; k++) begin
                s = '0;
                s.conf = sprite_conf_t'($urandom);
                for (int rr = 0; rr < 4; rr++)
                    for (int c = 0; c < 8; c++)
                        s.pat[rr][c] = ($urandom_range(0, 1) == 1) ?
                                       4'($urandom) : 4'd0;
                if (k < NS) send(s);
                else begin
                    sprite = s;
                    sprite_valid = 1'b1;
                end
                if ($urandom_range(0, 1) == 1) begin
                    sprite_valid = 1'b0;
                    cyc($urandom_range(1, 3));
                end
            end
            if ($urandom_range(0, 1) == 1) sprite_valid = 1'b0;
            run_draw();
            sprite_valid = 1'b0;
            chk("rnd_vcnt", vcnt, 256);
            chk("rnd_done_x", done_x, 255);
        end

        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
